// File: rtl/lane_resize_fifo.sv
// Lane-granular circular buffer. It accepts up to S_LANES lanes per beat and emits M_LANES lanes per beat.
// Optional macro RESIZE_FLUSH_EN adds per-lane last flags, so a packet tail is emitted as a short beat.
module lane_resize_fifo #(
    parameter int LANE_W  = 3,
    parameter int S_LANES = 3,
    parameter int M_LANES = 2,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [S_LANES*LANE_W-1:0]         s_tdata,
    input  logic [$clog2(S_LANES+1)-1:0]      s_tlanes,
    input  logic                              s_tlast,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    output logic [M_LANES*LANE_W-1:0]         m_tdata,
    output logic [$clog2(M_LANES+1)-1:0]      m_tlanes,
    output logic                              m_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [CNT_W-1:0]                  level
);
    localparam int SL_W  = $clog2(S_LANES + 1);
    localparam int ML_W  = $clog2(M_LANES + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [LANE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [SL_W-1:0]   n_wr;
    logic [SL_W-1:0]   wr_cnt;
    logic [ML_W-1:0]   rd_cnt;
    logic [ML_W-1:0]   hit_lanes;
    logic              hit;
    logic              wr_en;
    logic              rd_en;

`ifdef RESIZE_FLUSH_EN
    logic [DEPTH-1:0]  flag;
`else
    logic              unused_tlast;
    assign unused_tlast = s_tlast;
`endif

    // Oversized lane counts are clamped rather than trusted.
    assign n_wr     = (s_tlanes > SL_W'(S_LANES)) ? SL_W'(S_LANES) : s_tlanes;
    assign s_tready = (CNT_W'(DEPTH) - level) >= CNT_W'(S_LANES);
    assign wr_en    = s_tvalid && s_tready;
    assign rd_en    = m_tvalid && m_tready;
    assign wr_cnt   = wr_en ? n_wr : '0;
    assign rd_cnt   = rd_en ? m_tlanes : '0;

    always_comb begin
        hit       = 1'b0;
        hit_lanes = ML_W'(M_LANES);
        m_tdata   = '0;
`ifdef RESIZE_FLUSH_EN
        // Only lanes actually stored are searched, and the first flag ends the beat.
        for (int j = 0; j < M_LANES; j++) begin
            if (!hit && (CNT_W'(j) < level) && flag[rptr + PTR_W'(j)]) begin
                hit       = 1'b1;
                hit_lanes = ML_W'(j + 1);
            end
        end
`endif
        m_tvalid = (level >= CNT_W'(M_LANES)) || hit;
        m_tlanes = m_tvalid ? hit_lanes : '0;
        m_tlast  = m_tvalid && hit;
        for (int j = 0; j < M_LANES; j++) begin
            m_tdata[j*LANE_W +: LANE_W] = m_tvalid ? mem[rptr + PTR_W'(j)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(wr_cnt);
            rptr  <= rptr + PTR_W'(rd_cnt);
            level <= level + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < S_LANES; i++) begin
                if (SL_W'(i) < n_wr) begin
                    mem[wptr + PTR_W'(i)] <= s_tdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

`ifdef RESIZE_FLUSH_EN
    // Read clears and write sets never touch the same lane, because of the free-space check.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= '0;
        end else begin
            if (rd_en) begin
                for (int j = 0; j < M_LANES; j++) begin
                    if (ML_W'(j) < m_tlanes) begin
                        flag[rptr + PTR_W'(j)] <= 1'b0;
                    end
                end
            end
            if (wr_en) begin
                for (int i = 0; i < S_LANES; i++) begin
                    if (SL_W'(i) < n_wr) begin
                        flag[wptr + PTR_W'(i)] <= s_tlast && (SL_W'(i + 1) == n_wr);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_resize_fifo.sv
// Bench for lane_resize_fifo: a queue-based lane model is checked against the DUT every cycle.
// The model also honours RESIZE_FLUSH_EN when the macro is defined.
module tb_lane_resize_fifo;
    localparam int LANE_W = 3;
    localparam int S      = 3;
    localparam int M      = 2;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
`ifdef RESIZE_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [S*LANE_W-1:0]  s_tdata;
    logic [1:0]           s_tlanes;
    logic                 s_tlast;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [M*LANE_W-1:0]  m_tdata;
    logic [1:0]           m_tlanes;
    logic                 m_tlast;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [CNT_W-1:0]     level;

    int n_checks = 0;
    int n_fail   = 0;
    int q_data[$];
    bit q_last[$];
    int out_log[$];
    bit last_wr;
    int last_n;

    lane_resize_fifo #(.LANE_W(LANE_W), .S_LANES(S), .M_LANES(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tlanes(s_tlanes), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlanes(m_tlanes), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_out(output bit v, output int lanes, output bit last);
        int lim;
        lim   = (q_data.size() < M) ? q_data.size() : M;
        last  = 1'b0;
        lanes = M;
        if (FLUSH) begin
            for (int j = 0; j < lim; j++) begin
                if (q_last[j]) begin
                    last  = 1'b1;
                    lanes = j + 1;
                    break;
                end
            end
        end
        v = (q_data.size() >= M) || last;
        if (!v) lanes = 0;
    endfunction

    task automatic compare_all();
        bit v;
        int ml;
        bit lst;
        model_out(v, ml, lst);
        check_val("level", int'(level), q_data.size());
        check_val("s_tready", int'(s_tready), int'((DEPTH - q_data.size()) >= S));
        check_val("m_tvalid", int'(m_tvalid), int'(v));
        check_val("m_tlanes", int'(m_tlanes), ml);
        check_val("m_tlast", int'(m_tlast), int'(lst));
        if (v) begin
            for (int j = 0; j < ml; j++)
                check_val("m_lane", int'(m_tdata[j*LANE_W +: LANE_W]), q_data[j]);
        end else begin
            check_val("m_tdata_idle", int'(m_tdata), 0);
        end
    endtask

    // Inputs are already driven; advance one clock, update the model, then compare.
    task automatic tick();
        bit v;
        int ml;
        bit lst;
        bit wr;
        bit rd;
        int n;
        model_out(v, ml, lst);
        n  = (int'(s_tlanes) > S) ? S : int'(s_tlanes);
        wr = !rst && s_tvalid && ((DEPTH - q_data.size()) >= S);
        rd = !rst && v && m_tready;
        if (rd) begin
            for (int j = 0; j < ml; j++) out_log.push_back(int'(m_tdata[j*LANE_W +: LANE_W]));
        end
        @(posedge clk);
        if (rst) begin
            q_data.delete();
            q_last.delete();
        end else begin
            if (rd) begin
                for (int j = 0; j < ml; j++) begin
                    void'(q_data.pop_front());
                    void'(q_last.pop_front());
                end
            end
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    q_data.push_back(int'(s_tdata[i*LANE_W +: LANE_W]));
                    q_last.push_back(FLUSH && s_tlast && (i == n - 1));
                end
            end
        end
        last_wr = wr;
        last_n  = n;
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input int lanes, input int d0, input int d1, input int d2,
                         input bit last, input bit rdy);
        s_tvalid = v;
        s_tlanes = 2'(lanes);
        s_tdata  = {LANE_W'(d2), LANE_W'(d1), LANE_W'(d0)};
        s_tlast  = last;
        m_tready = rdy;
    endtask

    initial begin
        int acc;
        int sent;
        int cyc;

        // Reset, with a live handshake offered that must be discarded.
        rst = 1'b1;
        drive(1, 3, 1, 2, 3, 1, 1);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_val("rst_s_tready", int'(s_tready), 1);
        check_val("rst_m_tvalid", int'(m_tvalid), 0);
        check_val("rst_level", int'(level), 0);
        check_val("rst_m_tdata", int'(m_tdata), 0);

        // Resizing 3-lane beats into 2-lane beats.
        out_log.delete();
        drive(1, 3, 1, 2, 3, 0, 1);
        tick();
        drive(1, 3, 4, 5, 6, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        check_val("resize_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) check_val("resize_order", out_log[i], i + 1);
        check_val("resize_level", int'(level), 0);

        // Full boundary.
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            drive(1, 3, 3 * k, 3 * k + 1, 3 * k + 2, 0, 0);
            if (s_tready) acc++;
            tick();
        end
        check_val("full_accepts", acc, 5);
        check_val("full_level", int'(level), 15);
        check_val("full_s_tready", int'(s_tready), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        check_val("full_read_level", int'(level), 13);
        check_val("full_read_s_tready", int'(s_tready), 1);

        // Simultaneous write and read.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 3, 1, 2, 3, 0, 0);
        tick();
        drive(1, 1, 4, 0, 0, 0, 0);
        tick();
        check_val("sim_level_before", int'(level), 4);
        drive(1, 3, 5, 6, 7, 0, 1);
        tick();
        check_val("sim_level_after", int'(level), 5);

        // Randomized sequential stream across pointer wrap.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        out_log.delete();
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 2000) begin
            int lanes;
            lanes = $urandom_range(0, 3);
            if (lanes > 40 - sent) lanes = 40 - sent;
            drive($urandom_range(0, 3) != 0, lanes, sent & 7, (sent + 1) & 7, (sent + 2) & 7,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            tick();
            if (last_wr) sent += last_n;
            cyc++;
        end
        check_val("wrap_done", int'(sent >= 40), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 25; i++) tick();
        check_val("wrap_total", out_log.size() + int'(level), 40);
        for (int i = 0; i < out_log.size(); i++) check_val("wrap_order", out_log[i], i & 7);

        // Packet tail.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 3, 7, 1, 2, 1, 0);
        tick();
        check_val("tail_head_valid", int'(m_tvalid), 1);
        check_val("tail_head_lane0", int'(m_tdata[2:0]), 7);
        check_val("tail_head_lane1", int'(m_tdata[5:3]), 1);
        check_val("tail_head_last", int'(m_tlast), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
`ifdef RESIZE_FLUSH_EN
        check_val("tail_valid", int'(m_tvalid), 1);
        check_val("tail_lanes", int'(m_tlanes), 1);
        check_val("tail_last", int'(m_tlast), 1);
        check_val("tail_lane0", int'(m_tdata[2:0]), 2);
        tick();
        check_val("tail_drained", int'(level), 0);
`else
        check_val("tail_held_valid", int'(m_tvalid), 0);
        check_val("tail_held_level", int'(level), 1);
        drive(1, 1, 3, 0, 0, 0, 0);
        tick();
        check_val("tail_join_valid", int'(m_tvalid), 1);
        check_val("tail_join_lane0", int'(m_tdata[2:0]), 2);
        check_val("tail_join_lane1", int'(m_tdata[5:3]), 3);
        check_val("tail_join_last", int'(m_tlast), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lane_resize_fifo.md
Name: lane_resize_fifo

Overview:
- Lane-granular circular buffer for the stream resizer.
- Accepts up to S_LANES lanes per input beat and emits exactly M_LANES lanes per output beat (fewer only at a flushed packet end).
- Manages its own write/read pointers, occupancy and valid/ready handshakes, so callers no longer compute bit pointers externally.
- Sits between the slave-side unpacker and the master-side packer.

Parameters:
- LANE_W, 3, bits per lane (data plus per-lane side bits), >=1.
- S_LANES, 3, input lanes per beat, >=1.
- M_LANES, 2, output lanes per beat, >=1.
- DEPTH, 16, buffer capacity in lanes; power of two, >= 2*max(S_LANES,M_LANES).
- CNT_W, $clog2(DEPTH+1), width of the level output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  S_LANES*LANE_W  input lanes; lane i occupies bits [i*LANE_W +: LANE_W].
- s_tlanes  in  $clog2(S_LANES+1)  count of valid lanes, packed from lane 0.
- s_tlast  in  1  input beat ends a packet.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  buffer can take a full S_LANES beat.
- m_tdata  out  M_LANES*LANE_W  output lanes, same packing as s_tdata.
- m_tlanes  out  $clog2(M_LANES+1)  valid lanes in the output beat.
- m_tlast  out  1  output beat ends a packet.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accepts.
- level  out  CNT_W  lanes currently stored.

Behaviour:
- Reset (rst=1 at a clock edge): wptr=0, rptr=0, level=0, all per-lane last flags cleared. Lane data storage is not reset.
- Outputs after reset: s_tready=1, m_tvalid=0, m_tdata=0, m_tlanes=0, m_tlast=0.
- rst takes priority over any same-cycle handshake; an in-flight transfer is discarded.
- Pointers are lane indices modulo DEPTH; wrap-around is seamless, so lanes of one beat may straddle index DEPTH-1 to 0.
- s_tready = (DEPTH - level) >= S_LANES, derived combinationally from the registered level. It is conservative: a partial beat is never accepted early.
- Write fires on s_tvalid && s_tready. Let n = min(s_tlanes, S_LANES).
  - Lanes 0..n-1 are stored at (wptr+i) mod DEPTH.
  - wptr += n.
  - Lanes >= n are ignored.
- s_tlanes values above S_LANES are clamped to S_LANES.
- A beat with n=0 is accepted and has no effect, including its s_tlast.
- Output is fall-through from registered storage.
  - m_tdata lane j = storage[(rptr+j) mod DEPTH].
  - A lane written at edge N is readable in the cycle after edge N (1-cycle write-to-read latency).
- m_tvalid = level >= M_LANES. With the optional feature compiled in, m_tvalid is also asserted by a last flag (see Optional Feature).
- Read fires on m_tvalid && m_tready: rptr += m_tlanes, level -= m_tlanes.
- Simultaneous write and read in one cycle: level_next = level + n - m_tlanes. No ordering hazard, because a write never lands in lanes being read (the free-space check guarantees it).
- When m_tvalid=0, m_tdata, m_tlanes and m_tlast are forced to 0.
- Full boundary: level > DEPTH-S_LANES gives s_tready=0. level never exceeds DEPTH.
- Empty boundary: level < M_LANES with no pending last gives m_tvalid=0. level never underflows.
- Full-beat mode: m_tlanes = M_LANES and m_tlast = 0 whenever valid.

Optional Feature:
- Macro: RESIZE_FLUSH_EN.
- Defined:
  - Storage carries one last-flag bit per lane.
  - On a write with s_tlast=1 and n>0, the flag is set on lane (wptr+n-1) only; all other written lanes get flag=0.
  - Let k be the index of the first flagged lane among the first min(level,M_LANES) lanes at rptr.
  - If such a lane exists: m_tvalid=1, m_tlanes=k+1, m_tlast=1, and lanes after the flag are not merged into this beat.
  - Otherwise behaviour is as in full-beat mode.
  - A read clears the flags of the lanes it consumes.
- Undefined:
  - s_tlast is ignored and m_tlast is tied 0.
  - Partial tail lanes wait until enough lanes arrive to fill a beat.
  - No flag storage is instantiated.

Test Plan (S_LANES=3, M_LANES=2, LANE_W=3, DEPTH=16):
- Reset check: rst=1 for 2 cycles, then release → s_tready=1, m_tvalid=0, level=0, m_tdata=0.
- Resizing: write beats {1,2,3} and {4,5,6} (n=3 each), m_tready=1 → output beats {1,2},{3,4},{5,6}; level returns to 0.
- Full boundary: m_tready=0, write 3-lane beats until blocked → 5 beats accepted, level=15, s_tready=0. Pulse m_tready for one read → level=13 and s_tready returns to 1.
- Wrap-around: stream 40 sequential lane values with random s_tvalid/m_tready → output order is exact across pointer wrap, with no loss or duplication.
- Simultaneous: level=4, write 3 and read 2 in the same cycle → level=5 at the next cycle.
- Flush (RESIZE_FLUSH_EN): write {7,1,2} with n=3, s_tlast=1 → beats {7,1} with m_tlast=0, then {2} with m_tlanes=1 and m_tlast=1. Without the macro, {2} is held until another lane arrives.
